// File: rtl/word_bus_arbiter.sv
// Round-robin owner arbiter for the shared word bus: grants one requester at a time,
// inserts a one-cycle turnaround gap between owners and optionally limits hold time.
module word_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       done,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic [1:0]            bus_sel,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  timeout_evt
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            tout_q, tout_d;

    logic [WIDTH-1:0] words [NREQ];
    logic [NREQ-1:0]  rot_req;
    logic [1:0]       pick_off;
    logic [1:0]       pick_idx;
    logic             pick_valid;
    logic             owner_req;
    logic             owner_done;
    logic             limit_hit;
    logic             release_own;

    // rot_req[k] is the request k places after the pointer, so the lowest set bit wins.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign words[gi]   = data_in[gi*WIDTH +: WIDTH];
            assign rot_req[gi] = req[ptr_q + 2'(gi)];
        end
    endgenerate

    always_comb begin
        pick_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off = 2'(k);
            end
        end
    end

    assign pick_valid = |req;
    assign pick_idx   = ptr_q + pick_off;

    assign owner_req   = req[sel_q];
    assign owner_done  = done[sel_q];
    assign limit_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_own = owner_done || !owner_req || limit_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        tout_d  = 1'b0;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (pick_valid) begin
                    state_d           = S_OWN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    hold_d            = '0;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_OWN: begin
                hold_d = hold_q + HW'(1);
                if (release_own) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    ptr_d   = sel_q + 2'd1;
                    // A timeout is flagged only when the limit alone forced the release.
                    tout_d  = limit_hit && owner_req && !owner_done;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            tout_q  <= tout_d;
        end
    end

    assign grant       = grant_q;
    assign bus_sel     = sel_q;
    assign bus_valid   = (state_q == S_OWN);
    assign bus_data    = bus_valid ? words[sel_q] : '0;
    assign timeout_evt = tout_q;

endmodule

// File: tb/tb_word_bus_arbiter.sv
// Directed bench for word_bus_arbiter: expected bus state per cycle is queued with the
// stimulus and compared one edge later; grant/valid invariants are checked every cycle.
module tb_word_bus_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   done = '0;
    logic [127:0] data_in;
    logic [3:0]   grant;
    logic [1:0]   bus_sel;
    logic         bus_valid;
    logic [31:0]  bus_data;
    logic         timeout_evt;

    int checks = 0;
    int failures = 0;
    int stepno = 0;

    logic [31:0] words [4];

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] data;
        logic        tout;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    word_bus_arbiter #(.NREQ(4), .WIDTH(32), .MAX_HOLD(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .data_in    (data_in),
        .grant      (grant),
        .bus_sel    (bus_sel),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .timeout_evt(timeout_evt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, stepno, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue what the bus must show after the edge, then compare.
    task automatic cyc(input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] eg, input logic [1:0] es, input logic et);
        exp_t e;
        req     = r;
        done    = d;
        e.grant = eg;
        e.sel   = es;
        e.valid = |eg;
        e.data  = (|eg) ? words[es] : 32'h0;
        e.tout  = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        stepno++;
        e = exp_q.pop_front();
        $display("step %0d req=%b done=%b grant=%b sel=%0d valid=%b data=%h tout=%b",
                 stepno, r, d, grant, bus_sel, bus_valid, bus_data, timeout_evt);
        chk("grant", 32'(grant), 32'(e.grant));
        chk("bus_sel", 32'(bus_sel), 32'(e.sel));
        chk("bus_valid", 32'(bus_valid), 32'(e.valid));
        chk("bus_data", bus_data, e.data);
        chk("timeout_evt", 32'(timeout_evt), 32'(e.tout));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_sel"}, 32'(bus_sel), 32'h0);
        chk({tag, "_valid"}, 32'(bus_valid), 32'h0);
        chk({tag, "_data"}, bus_data, 32'h0);
        chk({tag, "_tout"}, 32'(timeout_evt), 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ($onehot0(grant) && (bus_valid == (|grant))) else begin
                failures++;
                $error("FAIL invariant observed grant=%b valid=%b expected onehot0 and valid==|grant",
                       grant, bus_valid);
            end
        end
    end

    initial begin
        logic [3:0] oh;
        words[0] = 32'hA0A0_0001;
        words[1] = 32'hB1B1_0002;
        words[2] = 32'hDEAD_BEEF;
        words[3] = 32'hC3C3_0004;
        data_in  = {words[3], words[2], words[1], words[0]};

        // Single requester 2 after reset; data passes through only while owned.
        do_reset();
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // All four request; each owner signals done on its third owned cycle.
        do_reset();
        for (int o = 0; o < 4; o++) begin
            oh = 4'b0001 << o;
            for (int c = 0; c < 3; c++) cyc(4'b1111, 4'b0000, oh, 2'(o), 1'b0);
            cyc(4'b1111, oh, 4'b0000, 2'(o), 1'b0);
        end
        cyc(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Hold limit: 16 owned cycles, timeout gap, re-grant; then done coinciding with limit.
        do_reset();
        repeat (16) cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        repeat (15) cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Non-owner done is ignored; owner 2 waits for owner 1's release plus the gap.
        do_reset();
        cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0110, 4'b0010, 4'b0000, 2'd1, 1'b0);
        cyc(4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // Asynchronous reset mid-ownership clears outputs and the pointer.
        do_reset();
        cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
        cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        cyc(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        cyc(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);

        // Owner 0 drops req with 1 pending; the pointer then favours 1 over a returning 0.
        do_reset();
        cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
